// File: rtl/lb_defs.sv
// Shared definitions for the line_buff_window slice: default geometry,
// a constant clog2 helper and the tap-slice macro used to pack col_out.
`ifndef LB_DEFS_SV
`define LB_DEFS_SV

// Bit slice of tap k inside a packed column of w-bit pixels.
`define LB_TAP(k, w) ((k) * (w)) +: (w)

package lb_defs;

    localparam int LB_DATA_W   = 8;
    localparam int LB_LINE_W   = 1600;
    localparam int LB_NUM_TAPS = 3;

    function automatic int lb_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/line_ram.sv
// One line of pixel storage: synchronous 1-cycle registered read, write enable,
// read-before-write when the read and write addresses coincide.
module line_ram
    import lb_defs::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int DEPTH  = LB_LINE_W,
    parameter int AW     = lb_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array; contents are deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register samples the old word, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/line_buff_window.sv
// Streaming multi-line buffer: one vertical column of NUM_TAPS pixels per accepted
// raster pixel. Optional top-border zero padding under macro LB_ZERO_PAD_EN.
module line_buff_window
    import lb_defs::*;
#(
    parameter int DATA_W   = LB_DATA_W,
    parameter int LINE_W   = LB_LINE_W,
    parameter int NUM_TAPS = LB_NUM_TAPS,
    parameter int COL_W    = lb_clog2(LINE_W)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sof_in,
    input  logic                         pix_valid_in,
    input  logic [DATA_W-1:0]            pix_in,
    output logic                         col_valid_out,
    output logic [NUM_TAPS*DATA_W-1:0]   col_out,
    output logic [COL_W-1:0]             col_idx_out,
    output logic                         eol_out,
    output logic                         primed_out
);

    localparam int LN_W = lb_clog2(NUM_TAPS);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_W - 1);
    localparam logic [LN_W-1:0]  LINE_LAST = LN_W'(NUM_TAPS - 1);

    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_eff_s;
    logic [COL_W-1:0] col_d_r;
    logic [LN_W-1:0]  line_r;
    logic [LN_W-1:0]  line_eff_s;
    logic             accept_s;
    logic             last_col_s;
    logic             primed_s;
    logic             wr_d_r;
    logic [DATA_W-1:0] pix_r;
    logic [NUM_TAPS-1:0][DATA_W-1:0] tap_s;

    // Position of the pixel being accepted; sof restarts the frame at (0,0).
    always_comb begin
        accept_s = pix_valid_in;
        if (pix_valid_in && sof_in) begin
            col_eff_s  = '0;
            line_eff_s = '0;
        end else begin
            col_eff_s  = col_r;
            line_eff_s = line_r;
        end
        last_col_s = (col_eff_s == COL_LAST);
        primed_s   = (line_eff_s == LINE_LAST);
    end

    // Column and saturating line counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r  <= '0;
            line_r <= '0;
        end else if (accept_s) begin
            if (last_col_s) begin
                col_r  <= '0;
                line_r <= primed_s ? LINE_LAST : (line_eff_s + LN_W'(1));
            end else begin
                col_r  <= col_eff_s + COL_W'(1);
                line_r <= line_eff_s;
            end
        end
    end

    // Downstream RAMs are written one cycle after the read that produced their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_d_r  <= 1'b0;
            col_d_r <= '0;
        end else begin
            wr_d_r <= accept_s;
            if (accept_s) begin
                col_d_r <= col_eff_s;
            end
        end
    end

    assign tap_s[0] = pix_r;

    for (genvar k = 0; k < NUM_TAPS - 1; k++) begin : g_ram
        logic              we_s;
        logic [COL_W-1:0]  waddr_s;
        logic [DATA_W-1:0] wdata_s;

        if (k == 0) begin : g_head
            assign we_s    = accept_s;
            assign waddr_s = col_eff_s;
            assign wdata_s = pix_in;
        end else begin : g_tail
            assign we_s    = wr_d_r;
            assign waddr_s = col_d_r;
            assign wdata_s = tap_s[k];
        end

        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (LINE_W),
            .AW     (COL_W)
        ) u_line_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .re    (accept_s),
            .raddr (col_eff_s),
            .we    (we_s),
            .waddr (waddr_s),
            .wdata (wdata_s),
            .rdata (tap_s[k+1])
        );
    end

`ifdef LB_ZERO_PAD_EN
    logic [LN_W-1:0] line_out_r;

    // Output sideband registers, with the line of the column kept for padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_valid_out <= 1'b0;
            pix_r         <= '0;
            col_idx_out   <= '0;
            eol_out       <= 1'b0;
            primed_out    <= 1'b0;
            line_out_r    <= '0;
        end else begin
            col_valid_out <= accept_s;
            if (accept_s) begin
                pix_r       <= pix_in;
                col_idx_out <= col_eff_s;
                eol_out     <= last_col_s;
                primed_out  <= primed_s;
                line_out_r  <= line_eff_s;
            end
        end
    end

    // Rows above the top of the frame read as zero.
    always_comb begin
        col_out = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (LN_W'(k) <= line_out_r) begin
                col_out[`LB_TAP(k, DATA_W)] = tap_s[k];
            end else begin
                col_out[`LB_TAP(k, DATA_W)] = '0;
            end
        end
    end
`else
    // Output sideband registers; columns are only flagged once all rows exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_valid_out <= 1'b0;
            pix_r         <= '0;
            col_idx_out   <= '0;
            eol_out       <= 1'b0;
            primed_out    <= 1'b0;
        end else begin
            col_valid_out <= accept_s && primed_s;
            if (accept_s) begin
                pix_r       <= pix_in;
                col_idx_out <= col_eff_s;
                eol_out     <= last_col_s;
                primed_out  <= primed_s;
            end
        end
    end

    // Pack taps, current row in the low slice.
    always_comb begin
        col_out = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            col_out[`LB_TAP(k, DATA_W)] = tap_s[k];
        end
    end
`endif

endmodule

// File: tb/tb_line_buff_window.sv
// Directed self-checking bench for line_buff_window (LINE_W=4 instance plus a
// default-parameter instance); expectations follow LB_ZERO_PAD_EN when defined.
module tb_line_buff_window;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int NT = 3;
`ifdef LB_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof_in;
    logic        pix_valid_in;
    logic [7:0]  pix_in;
    logic        col_valid_out;
    logic [23:0] col_out;
    logic [1:0]  col_idx_out;
    logic        eol_out;
    logic        primed_out;

    logic        b_sof;
    logic        b_valid;
    logic [7:0]  b_pix;
    logic        b_col_valid;
    logic [23:0] b_col;
    logic [10:0] b_idx;
    logic        b_eol;
    logic        b_primed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_buff_window #(.DATA_W(DW), .LINE_W(LW), .NUM_TAPS(NT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sof_in        (sof_in),
        .pix_valid_in  (pix_valid_in),
        .pix_in        (pix_in),
        .col_valid_out (col_valid_out),
        .col_out       (col_out),
        .col_idx_out   (col_idx_out),
        .eol_out       (eol_out),
        .primed_out    (primed_out)
    );

    line_buff_window dut_big (
        .clk           (clk),
        .rst_n         (rst_n),
        .sof_in        (b_sof),
        .pix_valid_in  (b_valid),
        .pix_in        (b_pix),
        .col_valid_out (b_col_valid),
        .col_out       (b_col),
        .col_idx_out   (b_idx),
        .eol_out       (b_eol),
        .primed_out    (b_primed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sof, input logic [7:0] pix);
        sof_in       = sof;
        pix_valid_in = 1'b1;
        pix_in       = pix;
        @(posedge clk);
        #1;
        sof_in       = 1'b0;
        pix_valid_in = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(col_valid_out), 32'd0);
        chk({tag, "_col"}, 32'(col_out), 32'd0);
        chk({tag, "_idx"}, 32'(col_idx_out), 32'd0);
        chk({tag, "_eol"}, 32'(eol_out), 32'd0);
        chk({tag, "_primed"}, 32'(primed_out), 32'd0);
    endtask

    // Stream count pixels first, first+1, ... starting with sof; optional idle gap after each.
    task automatic stream(input int first, input int count, input bit gap, input string tag);
        logic [7:0]  v;
        logic [23:0] exp_col;
        logic        exp_valid;
        int          line;
        int          col;
        for (int i = 0; i < count; i++) begin
            v    = 8'(first + i);
            line = i / LW;
            if (line > NT - 1) line = NT - 1;
            col  = i % LW;
            exp_col   = {(line >= 2) ? (v - 8'd8) : 8'd0, (line >= 1) ? (v - 8'd4) : 8'd0, v};
            exp_valid = ZP || (line == NT - 1);
            push(i == 0, v);
            chk($sformatf("%s_valid_%0d", tag, i), 32'(col_valid_out), 32'(exp_valid));
            chk($sformatf("%s_primed_%0d", tag, i), 32'(primed_out), 32'(line == NT - 1));
            chk($sformatf("%s_idx_%0d", tag, i), 32'(col_idx_out), 32'(col));
            chk($sformatf("%s_eol_%0d", tag, i), 32'(eol_out), 32'(col == LW - 1));
            if (exp_valid) begin
                chk($sformatf("%s_col_%0d", tag, i), 32'(col_out), 32'(exp_col));
            end
            if (gap) begin
                idle();
                chk($sformatf("%s_gapvalid_%0d", tag, i), 32'(col_valid_out), 32'd0);
                chk($sformatf("%s_gapidx_%0d", tag, i), 32'(col_idx_out), 32'(col));
                chk($sformatf("%s_gapprimed_%0d", tag, i), 32'(primed_out), 32'(line == NT - 1));
                if (exp_valid) begin
                    chk($sformatf("%s_gapcol_%0d", tag, i), 32'(col_out), 32'(exp_col));
                end
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        sof_in       = 1'b0;
        pix_valid_in = 1'b0;
        pix_in       = 8'd0;
        b_sof        = 1'b0;
        b_valid      = 1'b0;
        b_pix        = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Basic continuous frame start.
        stream(1, 12, 1'b0, "s1");
        idle();
        // Alternating valid/idle cycles with fresh data.
        stream(21, 12, 1'b1, "s3");
        idle();
        // Mid-line sof abandons the partial line.
        stream(1, 10, 1'b0, "s4a");
        stream(100, 12, 1'b0, "s4b");
        idle();

        // Asynchronous reset mid-line 2, away from any clock edge.
        stream(41, 10, 1'b0, "s5a");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        stream(1, 12, 1'b0, "s5b");
        idle();

        // Default-parameter instance: three lines of ramp data.
        for (int i = 0; i < 3 * 1600; i++) begin
            b_sof   = (i == 0);
            b_valid = 1'b1;
            b_pix   = 8'(i);
            @(posedge clk);
            #1;
            b_sof   = 1'b0;
            b_valid = 1'b0;
            if (i == 1599) begin
                chk("big_r1_valid", 32'(b_col_valid), 32'(ZP));
                chk("big_r1_eol", 32'(b_eol), 32'd1);
                chk("big_r1_primed", 32'(b_primed), 32'd0);
            end
            if (i == 3200) begin
                chk("big_r2c0_col", 32'(b_col), {8'd0, 8'd0, 8'd64, 8'd128});
                chk("big_r2c0_idx", 32'(b_idx), 32'd0);
                chk("big_r2c0_primed", 32'(b_primed), 32'd1);
            end
            if (i == 4799) begin
                chk("big_last_valid", 32'(b_col_valid), 32'd1);
                chk("big_last_col", 32'(b_col), {8'd0, 8'd63, 8'd127, 8'd191});
                chk("big_last_idx", 32'(b_idx), 32'd1599);
                chk("big_last_eol", 32'(b_eol), 32'd1);
                chk("big_last_primed", 32'(b_primed), 32'd1);
            end
        end
        idle();
        chk("big_idle_valid", 32'(b_col_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
